// File: rtl/edge_fifo.sv
// -----------------------------------------------------------------------------
// edge_fifo
//
// Small synchronous FIFO that holds the timestamps of pending input edges for
// the delay line. Pointers carry one extra wrap bit so that full and empty can
// be told apart without a separate occupancy counter.
//
// Ports:
//   clk       rising-edge clock
//   rstN      asynchronous active-low reset (pointers only)
//   push      write wrData at the tail this cycle
//   pop       drop the head entry this cycle
//   flush     discard every entry; overrides push and pop
//   wrData    timestamp to store
//   headData  timestamp at the head (valid when empty is low)
//   full      FIFO_DEPTH entries stored
//   empty     no entries stored
//
// The caller never pushes into a full FIFO unless it pops in the same cycle;
// in that case the new entry lands in the slot the old head is leaving.
// -----------------------------------------------------------------------------
module edge_fifo #(
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] headData,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wrPtr;
   logic [AW:0]       rdPtr;

   // Pointer state
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTR_ONE;
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_ONE;
         end
      end
   end

   // Storage; contents need no reset because the pointers gate every read
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wrPtr[AW-1:0]] <= wrData;
      end
   end

   assign headData = mem[rdPtr[AW-1:0]];
   assign empty    = (wrPtr == rdPtr);
   assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/delay.sv
// -----------------------------------------------------------------------------
// delay
//
// Programmable delay line for a single binary signal. Instead of a long shift
// register, every transition of sigIn is stamped with a free-running counter
// and queued; once a queued edge is waitCnt cycles old, sigOut toggles.
//
// Ports:
//   clk       rising-edge clock
//   rstN      asynchronous active-low reset
//   sigIn     signal to delay, synchronous to clk
//   waitCnt   delay in clock cycles (0 behaves like 1)
//   sigOut    delayed copy of sigIn, registered
//   overflow  sticky: an edge was lost because the edge queue was full
// -----------------------------------------------------------------------------
module delay #(
   parameter int WAIT_CNT_SIZE = 11,
   parameter int FIFO_DEPTH    = 8
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     sigIn,
   input  logic [WAIT_CNT_SIZE-1:0] waitCnt,
   output logic                     sigOut,
   output logic                     overflow
);

   // One extra bit lets ages up to 2^WAIT_CNT_SIZE be computed exactly with
   // plain modulo subtraction, so counter wrap needs no special handling.
   localparam int CW = WAIT_CNT_SIZE + 1;
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          sIn;
   logic [CW-1:0] timeCnt;
   logic [CW-1:0] headStamp;
   logic [CW-1:0] age;
   logic          fifoFull;
   logic          fifoEmpty;
   logic          edgeDet;
   logic          releaseEdge;
   logic          lostEdge;
   logic          pushEdge;

   // Edge capture and release decisions
   assign edgeDet     = sigIn ^ sIn;
   assign age         = timeCnt - headStamp;
   assign releaseEdge = !fifoEmpty && (age >= {1'b0, waitCnt});
   // A full queue can still take a new edge if the head leaves this cycle.
   assign lostEdge    = edgeDet && fifoFull && !releaseEdge;
   assign pushEdge    = edgeDet && !lostEdge;

   edge_fifo #(
      .DATA_W     (CW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk      (clk),
      .rstN     (rstN),
      .push     (pushEdge),
      .pop      (releaseEdge),
      .flush    (lostEdge),
      .wrData   (timeCnt),
      .headData (headStamp),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // Sample register and timestamp counter
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sIn     <= 1'b0;
         timeCnt <= '0;
      end else begin
         sIn     <= sigIn;
         timeCnt <= timeCnt + CNT_ONE;
      end
   end

   // Output stage: replay edges, or resynchronise to sigIn after losing one
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         sigOut   <= 1'b0;
         overflow <= 1'b0;
      end else if (lostEdge) begin
         sigOut   <= sigIn;
         overflow <= 1'b1;
      end else if (releaseEdge) begin
         sigOut   <= ~sigOut;
      end
   end

endmodule

// File: tb/tb_delay.sv
module tb_delay;

   logic        clk;
   logic        rstN;
   logic        sigIn;
   logic [10:0] waitCnt;
   logic        sigOut;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   // Bench-side history of sampled sigIn (0 while in reset) for the lag model
   bit hist [4096];
   int cyc   = 0;
   int tcRel = 0;

   delay #(
      .WAIT_CNT_SIZE (11),
      .FIFO_DEPTH    (8)
   ) dut (
      .clk      (clk),
      .rstN     (rstN),
      .sigIn    (sigIn),
      .waitCnt  (waitCnt),
      .sigOut   (sigOut),
      .overflow (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      hist[cyc & 4095] <= rstN ? sigIn : 1'b0;
      cyc <= cyc + 1;
      tcRel <= rstN ? tcRel + 1 : 0;
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkModel(input string tag);
      int lag;
      lag = (waitCnt == 11'd0) ? 1 : int'(waitCnt);
      chk(tag, sigOut, hist[(cyc - 1 - lag) & 4095]);
   endtask

   task automatic holdModel(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         step();
         checkModel(tag);
      end
   endtask

   task automatic toggleRun(input int half, input int halves, input string tag);
      for (int h = 0; h < halves; h++) begin
         sigIn = ~sigIn;
         holdModel(half, tag);
      end
   endtask

   initial begin
      rstN    = 1'b0;
      sigIn   = 1'b0;
      waitCnt = 11'd8;

      // Power-on reset
      repeat (3) step();
      chk("por_sigOut", sigOut, 1'b0);
      chk("por_overflow", overflow, 1'b0);
      chk("por_empty", dut.uFifo.empty, 1'b1);
      rstN = 1'b1;

      // Fixed delay of 8, 32-cycle half period
      holdModel(10, "fix8_idle");
      toggleRun(32, 4, "fix8");

      // Delay change 8 -> 4 with three edges pending
      sigIn = 1'b1; step();
      sigIn = 1'b0; step();
      sigIn = 1'b1; step();
      step(); chk("chg_e3", sigOut, 1'b0);
      step(); chk("chg_e4", sigOut, 1'b0);
      step(); chk("chg_e5", sigOut, 1'b0);
      waitCnt = 11'd4;
      step(); chk("chg_e6", sigOut, 1'b1);
      step(); chk("chg_e7", sigOut, 1'b0);
      step(); chk("chg_e8", sigOut, 1'b1);
      step(); chk("chg_e9", sigOut, 1'b1);
      toggleRun(16, 4, "lag4");
      waitCnt = 11'd3;
      toggleRun(16, 4, "lag3");

      // waitCnt 1 and 0 both give one cycle of lag
      waitCnt = 11'd1;
      toggleRun(5, 4, "lag1");
      waitCnt = 11'd0;
      toggleRun(5, 4, "lag0");
      toggleRun(1, 6, "lag0_dense");
      sigIn = 1'b0;
      holdModel(4, "lag0_settle");

      // Maximum delay, pulse placed so its release crosses the counter wrap
      waitCnt = 11'd2047;
      while (tcRel < 3000) begin
         step();
         chk("max_idle", sigOut, 1'b0);
      end
      sigIn = 1'b1;
      for (int k = 0; k < 2060; k++) begin
         step();
         if (k == 4) sigIn = 1'b0;
         chk("max_pulse", sigOut, (k >= 2047) && (k < 2052));
      end

      // Dense edges: exactly FIFO_DEPTH toggles inside the window
      waitCnt = 11'd20;
      for (int i = 0; i < 8; i++) begin
         sigIn = ~sigIn;
         step();
         checkModel("dense_in");
      end
      chk("dense_full", dut.uFifo.full, 1'b1);
      chk("dense_ovf", overflow, 1'b0);
      holdModel(30, "dense_out");
      chk("dense_ovf_end", overflow, 1'b0);
      chk("dense_empty", dut.uFifo.empty, 1'b1);

      // Overflow: ninth toggle with the queue full
      for (int i = 0; i < 8; i++) begin
         sigIn = ~sigIn;
         step();
         checkModel("ovf_in");
      end
      chk("ovf_pre", overflow, 1'b0);
      sigIn = ~sigIn;
      step();
      chk("ovf_flag", overflow, 1'b1);
      chk("ovf_sigOut", sigOut, 1'b1);
      chk("ovf_empty", dut.uFifo.empty, 1'b1);
      for (int i = 0; i < 30; i++) begin
         step();
         chk("ovf_hold", sigOut, 1'b1);
         chk("ovf_sticky", overflow, 1'b1);
      end
      toggleRun(25, 4, "ovf_resume");
      chk("ovf_sticky_end", overflow, 1'b1);

      // Mid-run reset with edges pending and sigIn high
      waitCnt = 11'd8;
      sigIn = 1'b0; step();
      sigIn = 1'b1; step();
      step();
      chk("rst_pre_sigOut", sigOut, 1'b1);
      rstN = 1'b0;
      #2;
      chk("rst_sigOut", sigOut, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_empty", dut.uFifo.empty, 1'b1);
      repeat (10) step();
      rstN = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         chk("rst_rise", sigOut, k >= 8);
      end
      chk("rst_ovf_end", overflow, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
